cma_run_sequencer: RTL and testbench

- Host-side controller that runs one complete CMA job with no further host involvement.
- Streams pre-packed configuration words (context, data and instruction entries, each as {address, data}) from a synchronous source ROM onto the global write bus.
- Kicks the array, waits for DONE under a watchdog, then reads back a result window over the global read bus.
- Delivers results to the host through a valid/ready stream. Sits between the host/testbench FPGA logic and the CMA global bus pins.

---
 rtl/cma_run_sequencer_pkg.sv | 19 +
 rtl/cma_seq_watchdog.sv | 34 +++
 rtl/cma_run_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_cma_run_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cma_run_sequencer_pkg.sv
// Shared types and defaults for the CMA run sequencer: one-hot FSM encoding and kick address.
package cma_run_sequencer_pkg;

  typedef enum logic [7:0] {
    StIdle = 8'b0000_0001,
    StLoad = 8'b0000_0010,
    StKick = 8'b0000_0100,
    StWait = 8'b0000_1000,
    StRead = 8'b0001_0000,
    StCapt = 8'b0010_0000,
    StOut  = 8'b0100_0000,
    StEnd  = 8'b1000_0000
  } cma_state_e;

  localparam int unsigned    AddrWDef   = 12;
  localparam int unsigned    DataWDef   = 25;
  localparam logic [11:0]    KickAdrDef = 12'h880;

endpackage

// File: rtl/cma_seq_watchdog.sv
// Saturating cycle counter for the WAIT phase; hit flags the last allowed cycle, limit 0 disables.
module cma_seq_watchdog #(
  parameter int unsigned TMO_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             clr,
  input  logic [TMO_W-1:0] limit,
  output logic             hit
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = en && (limit != '0) && (cnt_q == (limit - TMO_W'(1)));

endmodule

// File: rtl/cma_run_sequencer.sv
// Runs one CMA job: streams config words from the source ROM, kicks the array, waits for DONE
// under a watchdog, then reads a result window back out through a valid/ready stream.
module cma_run_sequencer
  import cma_run_sequencer_pkg::*;
#(
  parameter int unsigned        ADDR_W   = AddrWDef,
  parameter int unsigned        DATA_W   = DataWDef,
  parameter int unsigned        SRC_AW   = 8,
  parameter int unsigned        RLEN_W   = 8,
  parameter int unsigned        TMO_W    = 16,
  parameter logic [ADDR_W-1:0]  KICK_ADR = KickAdrDef
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [SRC_AW-1:0]        CFG_BASE,
  input  logic [SRC_AW-1:0]        CFG_LEN,
  input  logic [ADDR_W-1:0]        RD_BASE,
  input  logic [RLEN_W-1:0]        RD_LEN,
  input  logic [TMO_W-1:0]         TIMEOUT,
  output logic [SRC_AW-1:0]        SRC_ADR,
  input  logic [ADDR_W+DATA_W-1:0] SRC_Q,
  output logic                     WE,
  output logic                     RE,
  output logic                     RUN,
  output logic                     BANK_SEL,
  output logic [ADDR_W-1:0]        GLB_ADR,
  output logic [DATA_W-1:0]        GLB_DOUT,
  input  logic [DATA_W-1:0]        GLB_DIN,
  input  logic                     DONE,
  output logic                     RES_VALID,
  input  logic                     RES_READY,
  output logic [DATA_W-1:0]        RES_DATA,
  output logic                     BUSY,
  output logic                     FIN,
  output logic                     ERR
);

  localparam int unsigned LcntW = SRC_AW + 1;

  cma_state_e state_q, state_d;

  logic [SRC_AW-1:0] cfg_len_q, cfg_len_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [RLEN_W-1:0] rd_len_q, rd_len_d;
  logic [RLEN_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [LcntW-1:0]  lcnt_q, lcnt_d;

  logic [SRC_AW-1:0] src_adr_q, src_adr_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              run_q, run_d;
  logic              bank_sel_q, bank_sel_d;
  logic [ADDR_W-1:0] glb_adr_q, glb_adr_d;
  logic [DATA_W-1:0] glb_dout_q, glb_dout_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              busy_q, busy_d;
  logic              fin_q, fin_d;
  logic              err_q, err_d;

  logic              wd_en, wd_clr, wd_hit;
  logic [LcntW-1:0]  lcnt_inc, cfg_len_ext;
  logic [RLEN_W-1:0] idx_inc;

  assign lcnt_inc    = lcnt_q + LcntW'(1);
  assign cfg_len_ext = {1'b0, cfg_len_q};
  assign idx_inc     = idx_q + RLEN_W'(1);

  assign wd_en  = (state_q == StWait);
  assign wd_clr = (state_q == StKick);

  cma_seq_watchdog #(
    .TMO_W (TMO_W)
  ) u_watchdog (
    .CLK   (CLK),
    .RST   (RST),
    .en    (wd_en),
    .clr   (wd_clr),
    .limit (tmo_q),
    .hit   (wd_hit)
  );

  always_comb begin
    state_d     = state_q;
    cfg_len_d   = cfg_len_q;
    rd_base_d   = rd_base_q;
    rd_len_d    = rd_len_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    lcnt_d      = lcnt_q;
    src_adr_d   = src_adr_q;
    we_d        = 1'b0;
    glb_adr_d   = glb_adr_q;
    glb_dout_d  = glb_dout_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          cfg_len_d = CFG_LEN;
          rd_base_d = RD_BASE;
          rd_len_d  = RD_LEN;
          tmo_d     = TIMEOUT;
          idx_d     = '0;
          lcnt_d    = '0;
          src_adr_d = CFG_BASE;
          err_d     = 1'b0;
          state_d   = (CFG_LEN == '0) ? StKick : StLoad;
        end
      end
      StLoad: begin
        // lcnt counts LOAD cycles; ROM word for address k lands in cycle k+1.
        lcnt_d = lcnt_inc;
        if (lcnt_inc < cfg_len_ext) begin
          src_adr_d = src_adr_q + SRC_AW'(1);
        end
        if ((lcnt_q != '0) && (lcnt_q <= cfg_len_ext)) begin
          we_d       = 1'b1;
          glb_adr_d  = SRC_Q[ADDR_W+DATA_W-1:DATA_W];
          glb_dout_d = SRC_Q[DATA_W-1:0];
        end
        if (lcnt_q == (cfg_len_ext + LcntW'(1))) begin
          state_d = StKick;
        end
      end
      StKick: begin
        state_d = StWait;
      end
      StWait: begin
        if (DONE) begin
          state_d = (rd_len_q == '0) ? StEnd : StRead;
        end else if (wd_hit) begin
          err_d   = 1'b1;
          state_d = StEnd;
        end
      end
      StRead: begin
        state_d = StCapt;
      end
      StCapt: begin
        res_data_d  = GLB_DIN;
        res_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (res_valid_q && RES_READY) begin
          res_valid_d = 1'b0;
          idx_d       = idx_inc;
          state_d     = (idx_inc == rd_len_q) ? StEnd : StRead;
        end
      end
      StEnd: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered outputs follow the state being entered so they line up with state_q.
    re_d       = (state_d == StRead);
    run_d      = (state_d == StKick) || (state_d == StWait);
    bank_sel_d = (state_d != StKick);
    fin_d      = (state_d == StEnd);
    busy_d     = (state_d != StIdle);
    if (state_d == StKick) begin
      glb_adr_d = KICK_ADR;
    end else if (state_d == StRead) begin
      glb_adr_d = rd_base_q + ADDR_W'(idx_d);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cfg_len_q   <= '0;
      rd_base_q   <= '0;
      rd_len_q    <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      lcnt_q      <= '0;
      src_adr_q   <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      run_q       <= 1'b0;
      bank_sel_q  <= 1'b1;
      glb_adr_q   <= '0;
      glb_dout_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_len_q   <= cfg_len_d;
      rd_base_q   <= rd_base_d;
      rd_len_q    <= rd_len_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      lcnt_q      <= lcnt_d;
      src_adr_q   <= src_adr_d;
      we_q        <= we_d;
      re_q        <= re_d;
      run_q       <= run_d;
      bank_sel_q  <= bank_sel_d;
      glb_adr_q   <= glb_adr_d;
      glb_dout_q  <= glb_dout_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      fin_q       <= fin_d;
      err_q       <= err_d;
    end
  end

  assign SRC_ADR   = src_adr_q;
  assign WE        = we_q;
  assign RE        = re_q;
  assign RUN       = run_q;
  assign BANK_SEL  = bank_sel_q;
  assign GLB_ADR   = glb_adr_q;
  assign GLB_DOUT  = glb_dout_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign BUSY      = busy_q;
  assign FIN       = fin_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_cma_run_sequencer.sv
// Scoreboard bench for cma_run_sequencer: directed jobs push expected bus/result traffic,
// a monitor process pops and compares whenever the DUT presents it.
module tb_cma_run_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  CFG_BASE = '0;
  logic [7:0]  CFG_LEN = '0;
  logic [11:0] RD_BASE = '0;
  logic [7:0]  RD_LEN = '0;
  logic [15:0] TIMEOUT = '0;
  logic [7:0]  SRC_ADR;
  logic [36:0] SRC_Q = '0;
  logic        WE, RE, RUN, BANK_SEL;
  logic [11:0] GLB_ADR;
  logic [24:0] GLB_DOUT;
  logic [24:0] GLB_DIN = '0;
  logic        DONE = 1'b0;
  logic        RES_VALID;
  logic        RES_READY = 1'b1;
  logic [24:0] RES_DATA;
  logic        BUSY, FIN, ERR;

  cma_run_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .CFG_BASE  (CFG_BASE),
    .CFG_LEN   (CFG_LEN),
    .RD_BASE   (RD_BASE),
    .RD_LEN    (RD_LEN),
    .TIMEOUT   (TIMEOUT),
    .SRC_ADR   (SRC_ADR),
    .SRC_Q     (SRC_Q),
    .WE        (WE),
    .RE        (RE),
    .RUN       (RUN),
    .BANK_SEL  (BANK_SEL),
    .GLB_ADR   (GLB_ADR),
    .GLB_DOUT  (GLB_DOUT),
    .GLB_DIN   (GLB_DIN),
    .DONE      (DONE),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_DATA  (RES_DATA),
    .BUSY      (BUSY),
    .FIN       (FIN),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  logic [36:0] rom [256];

  always @(posedge CLK) SRC_Q <= rom[SRC_ADR];

  function automatic logic [24:0] gmem(input logic [11:0] a);
    case (a)
      12'h010: return 25'h0A5;
      12'h011: return 25'h05A;
      default: return {13'h0, a};
    endcase
  endfunction

  always @(posedge CLK) if (RE) GLB_DIN <= gmem(GLB_ADR);

  logic [36:0] exp_wr [$];
  logic [11:0] exp_rd [$];
  logic [24:0] exp_res [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cnt, re_cnt, wait_cnt, kick_cnt, fin_cnt, first_we, kick_cyc;
  int stall_cfg = 0;
  int stall_used = 0;
  bit prev_we = 1'b0;
  bit pv_valid = 1'b0;
  bit pv_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic monitor();
    logic [36:0] e37;
    logic [11:0] e12;
    logic [24:0] e25;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        pv_valid = 1'b0;
        prev_we  = 1'b0;
      end else begin
        if (WE) begin
          we_cnt++;
          if (!prev_we) first_we = cyc;
          if (exp_wr.size() == 0) begin
            unexpected("wr_unexpected", 64'({GLB_ADR, GLB_DOUT}));
          end else begin
            e37 = exp_wr.pop_front();
            check("wr_adr_data", 64'({GLB_ADR, GLB_DOUT}), 64'(e37));
          end
        end
        prev_we = WE;
        if (RE) begin
          re_cnt++;
          check("re_while_valid", 64'(RES_VALID), 64'd0);
          if (exp_rd.size() == 0) begin
            unexpected("re_unexpected", 64'(GLB_ADR));
          end else begin
            e12 = exp_rd.pop_front();
            check("re_adr", 64'(GLB_ADR), 64'(e12));
          end
        end
        if (RUN && !BANK_SEL) begin
          kick_cnt++;
          kick_cyc = cyc;
          check("kick_adr", 64'(GLB_ADR), 64'h880);
          check("kick_we", 64'(WE), 64'd0);
        end
        if (RUN && BANK_SEL) wait_cnt++;
        if (FIN) fin_cnt++;
        if (pv_valid && !pv_ready) check("res_valid_hold", 64'(RES_VALID), 64'd1);
        if (RES_VALID) begin
          if (exp_res.size() == 0) begin
            unexpected("res_unexpected", 64'(RES_DATA));
          end else begin
            check("res_data", 64'(RES_DATA), 64'(exp_res[0]));
            if (RES_READY) e25 = exp_res.pop_front();
          end
        end
        pv_valid = RES_VALID;
        pv_ready = RES_READY;
      end
    end
  endtask

  // Holds RES_READY low for stall_cfg cycles on the first result word of each job.
  task automatic ready_drv();
    forever begin
      @(posedge CLK);
      #1;
      if (!BUSY) stall_used = 0;
      if (RES_VALID && (stall_used < stall_cfg)) begin
        RES_READY = 1'b0;
        stall_used++;
      end else begin
        RES_READY = 1'b1;
      end
    end
  endtask

  task automatic start_job(input logic [7:0] base, input logic [7:0] len,
                           input logic [11:0] rbase, input logic [7:0] rlen,
                           input logic [15:0] tmo);
    we_cnt = 0; re_cnt = 0; wait_cnt = 0; kick_cnt = 0; fin_cnt = 0;
    first_we = -1; kick_cyc = -1;
    CFG_BASE = base; CFG_LEN = len; RD_BASE = rbase; RD_LEN = rlen; TIMEOUT = tmo;
    START = 1'b1;
    tick();
    START = 1'b0;
    // Scramble descriptors to show the DUT latched them.
    CFG_BASE = 8'hAA; CFG_LEN = 8'h77; RD_BASE = 12'hFFF; RD_LEN = 8'h33; TIMEOUT = 16'h1;
  endtask

  task automatic wait_kick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (kick_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) unexpected("kick_timeout", 64'(cyc));
  endtask

  task automatic finish_job(input int exp_wait, input int exp_len, input int exp_re);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (fin_cnt > 0) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) unexpected("fin_timeout", 64'(cyc));
    DONE = 1'b0;
    tick();
    check("busy_after_fin", 64'(BUSY), 64'd0);
    check("fin_pulses", 64'(fin_cnt), 64'd1);
    check("kick_cycles", 64'(kick_cnt), 64'd1);
    if (exp_wait >= 0) check("wait_cycles", 64'(wait_cnt), 64'(exp_wait));
    check("we_count", 64'(we_cnt), 64'(exp_len));
    check("re_count", 64'(re_cnt), 64'(exp_re));
    if (exp_len > 0) check("load_to_kick", 64'(kick_cyc - first_we), 64'(exp_len));
    check("wr_left", 64'(exp_wr.size()), 64'd0);
    check("rd_left", 64'(exp_rd.size()), 64'd0);
    check("res_left", 64'(exp_res.size()), 64'd0);
  endtask

  task automatic run_job(input logic [7:0] base, input logic [7:0] len,
                         input logic [11:0] rbase, input logic [7:0] rlen,
                         input logic [15:0] tmo, input int done_dly, input bit poke,
                         input int exp_wait, input int exp_re);
    bit ok;
    if (done_dly == 0) DONE = 1'b1;
    start_job(base, len, rbase, rlen, tmo);
    wait_kick(ok);
    if (ok && (done_dly > 0)) begin
      for (int i = 0; i < done_dly; i++) begin
        if (poke && (i == 5)) START = 1'b1;
        tick();
        START = 1'b0;
      end
      DONE = 1'b1;
    end
    finish_job(exp_wait, int'(len), exp_re);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) rom[i] = {12'(i) + 12'h300, 25'(i)};
    rom[4]   = {12'h100, 25'h1};
    rom[5]   = {12'h101, 25'h2};
    rom[6]   = {12'h102, 25'h3};
    rom[255] = {12'h1FF, 25'h1234};
    rom[0]   = {12'h200, 25'h4321};

    fork
      monitor();
      ready_drv();
    join_none

    repeat (3) tick();
    check("rst_ctrl", 64'({WE, RE, RUN, RES_VALID, BUSY, FIN, ERR, BANK_SEL}), 64'h01);
    check("rst_glb_adr", 64'(GLB_ADR), 64'd0);
    check("rst_glb_dout", 64'(GLB_DOUT), 64'd0);
    check("rst_res_data", 64'(RES_DATA), 64'd0);
    check("rst_src_adr", 64'(SRC_ADR), 64'd0);
    RST = 1'b0;
    repeat (2) tick();

    // Config load, kick, DONE after 20 cycles, two-word readback; mid-job START ignored.
    exp_wr.push_back({12'h100, 25'h1});
    exp_wr.push_back({12'h101, 25'h2});
    exp_wr.push_back({12'h102, 25'h3});
    exp_rd.push_back(12'h010);
    exp_rd.push_back(12'h011);
    exp_res.push_back(25'h0A5);
    exp_res.push_back(25'h05A);
    run_job(8'd4, 8'd3, 12'h010, 8'd2, 16'd100, 20, 1'b1, 20, 2);
    check("err_after_ok", 64'(ERR), 64'd0);
    repeat (2) tick();

    // Watchdog expiry: eight WAIT cycles, ERR set, readback skipped.
    exp_wr.push_back({12'h102, 25'h3});
    run_job(8'd6, 8'd1, 12'h040, 8'd2, 16'd8, -1, 1'b0, 8, 0);
    check("err_timeout", 64'(ERR), 64'd1);
    repeat (2) tick();

    // Empty job with DONE tied high: straight KICK, one WAIT, END; clears ERR.
    run_job(8'd9, 8'd0, 12'h050, 8'd0, 16'd0, 0, 1'b0, 1, 0);
    check("err_cleared", 64'(ERR), 64'd0);
    repeat (2) tick();

    // Backpressure on the first word.
    stall_cfg = 10;
    exp_wr.push_back({12'h101, 25'h2});
    exp_rd.push_back(12'h020);
    exp_rd.push_back(12'h021);
    exp_res.push_back(25'h020);
    exp_res.push_back(25'h021);
    run_job(8'd5, 8'd1, 12'h020, 8'd2, 16'd0, 2, 1'b0, 2, 2);
    stall_cfg = 0;
    repeat (2) tick();

    // Reset during WAIT aborts immediately; a fresh job wrapping the ROM address follows.
    exp_wr.push_back({12'h100, 25'h1});
    exp_wr.push_back({12'h101, 25'h2});
    exp_wr.push_back({12'h102, 25'h3});
    start_job(8'd4, 8'd3, 12'h010, 8'd2, 16'd0);
    wait_kick(ok);
    repeat (3) tick();
    RST = 1'b1;
    #1;
    check("rst_mid_run", 64'(RUN), 64'd0);
    check("rst_mid_busy", 64'(BUSY), 64'd0);
    check("rst_mid_bank", 64'(BANK_SEL), 64'd1);
    exp_wr.delete();
    exp_rd.delete();
    exp_res.delete();
    tick();
    RST = 1'b0;
    repeat (2) tick();
    exp_wr.push_back({12'h1FF, 25'h1234});
    exp_wr.push_back({12'h200, 25'h4321});
    exp_rd.push_back(12'h011);
    exp_res.push_back(25'h05A);
    run_job(8'hFF, 8'd2, 12'h011, 8'd1, 16'd0, 3, 1'b0, 3, 1);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t, expected completion", $time);
    $fatal(1, "simulation did not complete");
  end

endmodule
